// File: rtl/dk_geom_pkg.sv
// Level geometry and encodings shared by the barrel engine.
// Holds floor/ladder tables, barrel size, hatch position, board limits
// and the per-slot state and animation encodings.
package dk_geom_pkg;

  localparam int BARREL_W  = 32;
  localparam int BARREL_H  = 24;
  localparam int HATCH_X   = 203;
  localparam int HATCH_Y   = 90;
  localparam int X_MIN     = 5;
  localparam int X_MAX     = 640;
  localparam int BOTTOM_LY = 461;

  localparam int unsigned N_FLOORS  = 6;
  localparam int unsigned N_LADDERS = 4;

  // Floors as (left x, top y, right x); a barrel rests on a floor when its
  // bottom edge equals the floor's y.
  localparam int FLOOR_LX [N_FLOORS] = '{250,   0,  49,   0,  49,   0};
  localparam int FLOOR_LY [N_FLOORS] = '{ 53, 115, 197, 286, 376, 461};
  localparam int FLOOR_RX [N_FLOORS] = '{388, 591, 640, 591, 640, 640};

  // Ladders as (floor index they start on, inclusive x window).
  localparam int LADDER_FLOOR [N_LADDERS] = '{  1,  2,   3,  4};
  localparam int LADDER_LO    [N_LADDERS] = '{539, 46, 544, 51};
  localparam int LADDER_HI    [N_LADDERS] = '{549, 56, 554, 61};

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'b00,
    SLOT_ROLL = 2'b01,
    SLOT_FALL = 2'b10
  } slot_state_t;

  localparam logic [2:0] ANIM_IDLE     = 3'b000;
  localparam logic [1:0] ANIM_FALL_PFX = 2'b10;

endpackage

// File: rtl/barrel_slot.sv
// One barrel slot: state machine, motion and animation counter.
// Ports:
//   clk, rst      clock / synchronous active-high reset
//   clr           force IDLE (level not running, or game over)
//   tick          frame enable; motion and animation advance only here
//   spawn_in      enter ROLL at the hatch (only honoured while IDLE)
//   rnd           2 random bits for the ladder decision
//   x, y, state, anim   registered position, state and sprite code
module barrel_slot
  import dk_geom_pkg::*;
#(
  parameter int unsigned SPEED_X     = 1,
  parameter int unsigned SPEED_Y     = 1,
  parameter int unsigned LADDER_MODE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       tick,
  input  logic       spawn_in,
  input  logic [1:0] rnd,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [1:0] state,
  output logic [2:0] anim
);

  localparam int         SX      = int'(SPEED_X);
  localparam int         SY      = int'(SPEED_Y);
  localparam logic [9:0] HX      = 10'(HATCH_X);
  localparam logic [8:0] HY      = 9'(HATCH_Y);

  slot_state_t st_q, st_d;
  logic [9:0]  x_d;
  logic [8:0]  y_d;
  logic        dir_left_q, dir_left_d;
  logic [4:0]  cnt_q, cnt_d;

  int   xi, bi, land_y;
  logic ovl, sup, bottom, on_ladder, land, descend;

  always_comb begin
    descend = (LADDER_MODE == 2) || ((LADDER_MODE == 1) && (rnd == 2'b10));
  end

  always_comb begin
    st_d       = st_q;
    x_d        = x;
    y_d        = y;
    dir_left_d = dir_left_q;
    cnt_d      = cnt_q;
    xi         = int'(x);
    bi         = int'(y) + BARREL_H;
    ovl        = 1'b0;
    sup        = 1'b0;
    bottom     = 1'b0;
    on_ladder  = 1'b0;
    land       = 1'b0;
    land_y     = 0;

    // Floor scan: support/ladder for rolling, strict downward crossing for
    // landing (so a ladder descent never re-lands on its own floor).
    for (int unsigned f = 0; f < N_FLOORS; f++) begin
      ovl = (xi < FLOOR_RX[f]) && (xi + BARREL_W > FLOOR_LX[f]);
      if (ovl && (bi == FLOOR_LY[f])) begin
        sup = 1'b1;
        if (FLOOR_LY[f] == BOTTOM_LY) bottom = 1'b1;
        for (int unsigned l = 0; l < N_LADDERS; l++) begin
          if ((LADDER_FLOOR[l] == int'(f)) && (xi >= LADDER_LO[l]) && (xi <= LADDER_HI[l]))
            on_ladder = 1'b1;
        end
      end
      if (ovl && (bi < FLOOR_LY[f]) && (FLOOR_LY[f] <= bi + SY)) begin
        land   = 1'b1;
        land_y = FLOOR_LY[f] - BARREL_H;
      end
    end

    if (clr) begin
      st_d       = SLOT_IDLE;
      x_d        = HX;
      y_d        = HY;
      dir_left_d = 1'b0;
      cnt_d      = '0;
    end else if (tick) begin
      unique case (st_q)
        SLOT_IDLE: begin
          if (spawn_in) begin
            st_d       = SLOT_ROLL;
            x_d        = HX;
            y_d        = HY;
            dir_left_d = 1'b0;
            cnt_d      = '0;
          end
        end
        SLOT_ROLL: begin
          cnt_d = cnt_q + 5'd1;
          if (bottom && (xi <= X_MIN)) begin
            st_d       = SLOT_IDLE;
            x_d        = HX;
            y_d        = HY;
            dir_left_d = 1'b0;
            cnt_d      = '0;
          end else if (!sup) begin
            st_d = SLOT_FALL;
          end else if (on_ladder && descend) begin
            st_d = SLOT_FALL;
          end else if (!dir_left_q) begin
            if (xi + BARREL_W + SX > X_MAX) begin
              x_d        = 10'(X_MAX - BARREL_W);
              dir_left_d = 1'b1;
            end else begin
              x_d = 10'(xi + SX);
            end
          end else begin
            if (!bottom && (xi - SX < X_MIN)) begin
              x_d        = 10'(X_MIN);
              dir_left_d = 1'b0;
            end else if (xi - SX < 0) begin
              x_d = '0;
            end else begin
              x_d = 10'(xi - SX);
            end
          end
        end
        SLOT_FALL: begin
          cnt_d = cnt_q + 5'd1;
          if (land) begin
            y_d        = 9'(land_y);
            st_d       = SLOT_ROLL;
            dir_left_d = !dir_left_q;
          end else begin
            y_d = 9'(int'(y) + SY);
          end
        end
        default: st_d = SLOT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= SLOT_IDLE;
      x          <= HX;
      y          <= HY;
      dir_left_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      st_q       <= st_d;
      x          <= x_d;
      y          <= y_d;
      dir_left_q <= dir_left_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state = st_q;
    unique case (st_q)
      SLOT_ROLL: anim = {1'b0, cnt_q[4:3]};
      SLOT_FALL: anim = {ANIM_FALL_PFX, cnt_q[4]};
      default:   anim = ANIM_IDLE;
    endcase
  end

endmodule

// File: rtl/barrel_pool.sv
// Multi-barrel hazard engine: spawns barrels at the hatch on a fixed period
// and runs N independent barrel slots.
// Ports:
//   clk, rst   clock / synchronous active-high reset
//   tick       frame enable
//   start      sets running; over clears it (over has priority)
//   x, y       packed per-slot position (10 / 9 bits per slot)
//   state      packed per-slot state (2 bits), anim packed sprite code (3 bits)
//   active     per-slot not-IDLE flag
//   spawn      one-cycle pulse when a barrel enters ROLL
module barrel_pool
  import dk_geom_pkg::*;
#(
  parameter int unsigned N_BARRELS    = 4,
  parameter int unsigned SPAWN_PERIOD = 240,
  parameter int unsigned SPEED_X      = 1,
  parameter int unsigned SPEED_Y      = 1,
  parameter int unsigned LADDER_MODE  = 1,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   start,
  input  logic                   over,
  output logic [10*N_BARRELS-1:0] x,
  output logic [9*N_BARRELS-1:0]  y,
  output logic [2*N_BARRELS-1:0]  state,
  output logic [3*N_BARRELS-1:0]  anim,
  output logic [N_BARRELS-1:0]    active,
  output logic                   spawn
);

  localparam int unsigned CW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_TERM = CW'(SPAWN_PERIOD - 1);

  logic                 running_q;
  logic [15:0]          lfsr_q;
  logic [CW-1:0]        cnt_q;
  logic [N_BARRELS-1:0] spawn_sel;
  logic                 idle_any, spawn_now, clr;

  always_ff @(posedge clk) begin
    if (rst || over) running_q <= 1'b0;
    else if (start)  running_q <= 1'b1;
  end

  // Galois form of x^16+x^14+x^13+x^11+1, free-running every clock.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < N_BARRELS; i++)
      active[i] = (state[2*i +: 2] != SLOT_IDLE);
  end

  always_comb begin
    spawn_sel = '0;
    idle_any  = 1'b0;
    for (int unsigned i = 0; i < N_BARRELS; i++) begin
      if (!active[i] && !idle_any) begin
        spawn_sel[i] = 1'b1;
        idle_any     = 1'b1;
      end
    end
  end

  always_comb begin
    clr       = !running_q || over;
    spawn_now = running_q && !over && tick && (cnt_q == CNT_TERM) && idle_any;
  end

  // With no idle slot the counter parks on its terminal value, so the spawn
  // fires on the first tick after any slot frees.
  always_ff @(posedge clk) begin
    if (rst || over || !running_q) begin
      cnt_q <= '0;
    end else if (tick) begin
      if (cnt_q == CNT_TERM) begin
        if (idle_any) cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) spawn <= 1'b0;
    else     spawn <= spawn_now;
  end

  for (genvar i = 0; i < N_BARRELS; i++) begin : g_slot
    barrel_slot #(
      .SPEED_X    (SPEED_X),
      .SPEED_Y    (SPEED_Y),
      .LADDER_MODE(LADDER_MODE)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .tick    (tick),
      .spawn_in(spawn_now && spawn_sel[i]),
      .rnd     (lfsr_q[2*i +: 2]),
      .x       (x[10*i +: 10]),
      .y       (y[9*i +: 9]),
      .state   (state[2*i +: 2]),
      .anim    (anim[3*i +: 3])
    );
  end

endmodule

// File: tb/tb_barrel_pool.sv
module tb_barrel_pool;

  logic clk, rst, tick, start, over;

  logic [39:0] xa;
  logic [35:0] ya;
  logic [7:0]  sa;
  logic [11:0] ana;
  logic [3:0]  acta;
  logic        spa;

  logic [9:0]  xb;
  logic [8:0]  yb;
  logic [1:0]  sb;
  logic [2:0]  anb;
  logic [0:0]  actb;
  logic        spb;

  int n_chk = 0;
  int n_fail = 0;
  int t_cnt = 0;
  int extra_sp = 0;

  barrel_pool #(
    .N_BARRELS(4), .SPAWN_PERIOD(4), .SPEED_X(1), .SPEED_Y(1),
    .LADDER_MODE(0), .LFSR_SEED(16'hACE1)
  ) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .over(over),
    .x(xa), .y(ya), .state(sa), .anim(ana), .active(acta), .spawn(spa)
  );

  barrel_pool #(
    .N_BARRELS(1), .SPAWN_PERIOD(4), .SPEED_X(1), .SPEED_Y(1),
    .LADDER_MODE(2), .LFSR_SEED(16'hACE1)
  ) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .over(over),
    .x(xb), .y(yb), .state(sb), .anim(anb), .active(actb), .spawn(spb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ax(input int i);  return 64'(xa[10*i +: 10]); endfunction
  function automatic logic [63:0] ay(input int i);  return 64'(ya[9*i +: 9]);   endfunction
  function automatic logic [63:0] ast(input int i); return 64'(sa[2*i +: 2]);   endfunction
  function automatic logic [63:0] aan(input int i); return 64'(ana[3*i +: 3]);  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic s, input logic o);
    tick = t; start = s; over = o;
    @(posedge clk); #1;
    tick = 1'b0; start = 1'b0; over = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (t_cnt < target) begin
      cyc(1'b1, 1'b0, 1'b0);
      t_cnt++;
      extra_sp += int'(spa);
    end
  endtask

  initial begin
    logic [3:0] exp_act;
    rst = 1'b1; tick = 1'b0; start = 1'b0; over = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    chk("rst_x",      64'(xa),   64'({4{10'd203}}));
    chk("rst_y",      64'(ya),   64'({4{9'd90}}));
    chk("rst_state",  64'(sa),   64'd0);
    chk("rst_anim",   64'(ana),  64'd0);
    chk("rst_active", 64'(acta), 64'd0);
    chk("rst_spawn",  64'(spa),  64'd0);
    chk("rst_b_x",    64'(xb),   64'd203);

    // Ticks without start: nothing may spawn.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("norun_active", 64'(acta), 64'd0);
    chk("norun_spawn",  64'(spa),  64'd0);

    cyc(1'b0, 1'b1, 1'b0);
    t_cnt = 0;

    for (int t = 1; t <= 20; t++) begin
      cyc(1'b1, (t == 10), 1'b0);
      t_cnt = t;
      exp_act = (t >= 16) ? 4'hF : (t >= 12) ? 4'h7 : (t >= 8) ? 4'h3 : (t >= 4) ? 4'h1 : 4'h0;
      chk($sformatf("spawn_T%0d", t),   64'(spa),  64'((t % 4 == 0) && (t <= 16)));
      chk($sformatf("active_T%0d", t),  64'(acta), 64'(exp_act));
      chk($sformatf("b_spawn_T%0d", t), 64'(spb),  64'(t == 4));
      if (t == 4) begin
        chk("T4_x", ax(0), 64'd203);
        chk("T4_y", ay(0), 64'd90);
        chk("T4_st", ast(0), 64'd1);
        chk("T4_anim", aan(0), 64'd0);
      end
      if (t == 5) begin
        chk("T5_st", ast(0), 64'd2);
        chk("T5_y", ay(0), 64'd90);
        chk("T5_anim", aan(0), 64'd4);
      end
      if (t == 6) begin
        chk("T6_st", ast(0), 64'd1);
        chk("T6_y", ay(0), 64'd91);
        chk("T6_x", ax(0), 64'd203);
      end
      if (t == 7) chk("T7_x", ax(0), 64'd202);
    end

    extra_sp = 0;
    run_to(204); chk("left_edge_x", ax(0), 64'd5);
    run_to(205); chk("left_clamp_x", ax(0), 64'd5);
    run_to(206); chk("left_turn_x", ax(0), 64'd6);

    // Mode-2 instance: ladder on floor 1 at x=539.
    run_to(739);
    chk("b_pre_ladder_x", 64'(xb), 64'd539);
    chk("b_pre_ladder_st", 64'(sb), 64'd1);
    chk("b_pre_ladder_anim", 64'(anb), 64'd3);
    run_to(740);
    chk("b_ladder_st", 64'(sb), 64'd2);
    chk("b_ladder_x", 64'(xb), 64'd539);
    chk("b_ladder_y", 64'(yb), 64'd91);
    chk("b_ladder_anim", 64'(anb), 64'd4);
    chk("a_no_ladder_x", ax(0), 64'd540);
    chk("a_no_ladder_st", ast(0), 64'd1);

    run_to(791);
    chk("a_edge_x", ax(0), 64'd591);
    chk("a_edge_st", ast(0), 64'd1);
    chk("a_edge_anim", aan(0), 64'd2);
    run_to(792);
    chk("a_fall_st", ast(0), 64'd2);
    chk("a_fall_x", ax(0), 64'd591);
    chk("a_fall_y", ay(0), 64'd91);
    chk("a_fall_anim", aan(0), 64'd5);
    run_to(796);
    chk("a1_fall_st", ast(1), 64'd2);
    chk("a1_fall_x", ax(1), 64'd591);

    run_to(821); chk("b_falling_y", 64'(yb), 64'd172);
    run_to(822);
    chk("b_land_st", 64'(sb), 64'd1);
    chk("b_land_y", 64'(yb), 64'd173);
    chk("b_land_x", 64'(xb), 64'd539);
    run_to(823); chk("b_land_dir_x", 64'(xb), 64'd538);

    run_to(873);
    chk("a_falling_y", ay(0), 64'd172);
    chk("a_falling_anim", aan(0), 64'd4);
    run_to(874);
    chk("a_land_st", ast(0), 64'd1);
    chk("a_land_y", ay(0), 64'd173);
    chk("a_land_anim", aan(0), 64'd0);
    run_to(875); chk("a_land_dir_x", ax(0), 64'd590);

    run_to(3455); chk("right_clamp_x", ax(0), 64'd608);
    run_to(3456); chk("right_turn_x", ax(0), 64'd607);

    run_to(4058);
    chk("pre_retire_x", ax(0), 64'd5);
    chk("pre_retire_y", ay(0), 64'd437);
    chk("pre_retire_st", ast(0), 64'd1);
    run_to(4059);
    chk("retire_st", ast(0), 64'd0);
    chk("retire_active", 64'(acta), 64'hE);
    chk("retire_x", ax(0), 64'd203);
    chk("retire_y", ay(0), 64'd90);
    chk("retire_anim", aan(0), 64'd0);
    chk("retire_spawn", 64'(spa), 64'd0);
    chk("held_no_spawn", 64'(extra_sp), 64'd0);
    run_to(4060);
    chk("respawn_pulse", 64'(spa), 64'd1);
    chk("respawn_active", 64'(acta), 64'hF);
    chk("respawn_st", ast(0), 64'd1);

    // Reset in flight.
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    chk("midrst_active", 64'(acta), 64'd0);
    chk("midrst_x", 64'(xa), 64'({4{10'd203}}));
    chk("midrst_y", 64'(ya), 64'({4{9'd90}}));
    chk("midrst_spawn", 64'(spa), 64'd0);
    chk("midrst_b_active", 64'(actb), 64'd0);

    cyc(1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 14; t++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk($sformatf("r2_spawn_T%0d", t), 64'(spa), 64'((t % 4 == 0) && (t <= 12)));
    end
    chk("pre_over_active", 64'(acta), 64'h7);

    // Game over coincident with a tick.
    cyc(1'b1, 1'b0, 1'b1);
    chk("over_active", 64'(acta), 64'd0);
    chk("over_state", 64'(sa), 64'd0);
    chk("over_x", 64'(xa), 64'({4{10'd203}}));
    chk("over_y", 64'(ya), 64'({4{9'd90}}));
    chk("over_anim", 64'(ana), 64'd0);
    chk("over_spawn", 64'(spa), 64'd0);

    cyc(1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 4; t++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk($sformatf("r3_spawn_T%0d", t), 64'(spa), 64'(t == 4));
      chk($sformatf("r3_active_T%0d", t), 64'(acta), 64'((t == 4) ? 1 : 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/barrel_pool.md
# barrel_pool

Multi-barrel hazard engine for the Donkey Kong level. It manages up to `N_BARRELS` independent barrel slots. It spawns a barrel at the hatch on a programmable period, and rolls each barrel along the platforms. Barrels fall off platform edges or descend ladders according to a selectable mode, and retire at the bottom-left exit. It sits between the game-control FSM (`start`/`over`/`tick`) and the sprite renderer and collision checker, which consume its flattened position, state and animation buses.

## Interface
Parameters:
- `N_BARRELS`, 4, number of slots; legal range 1..8.
- `SPAWN_PERIOD`, 240, ticks between spawns; must be ≥ 1.
- `SPEED_X`, 1, horizontal pixels per tick.
- `SPEED_Y`, 1, vertical pixels per tick.
- `LADDER_MODE`, 1, ladder behaviour: 0 = never descend, 1 = random descend, 2 = always descend.
- `LFSR_SEED`, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `tick` in 1: frame-rate enable; all motion and animation advance only on cycles with `tick`=1.
- `start` in 1: level pulse; sets `running`.
- `over` in 1: game over; clears `running`.
- `x` out 10·N: slot i occupies bits [10i+9:10i].
- `y` out 9·N: slot i occupies bits [9i+8:9i].
- `state` out 2·N: per-slot state: 00 IDLE, 01 ROLL, 10 FALL.
- `anim` out 3·N: per-slot sprite code: 000–011 roll frames, 100/101 fall frames.
- `active` out N: 1 when the slot is not IDLE.
- `spawn` out 1: one-cycle pulse when a barrel is spawned.

## Operation
- `running` flag:
  - `rst` or `over` clears it (`over` wins over `start`).
  - `start` sets it.
  - While `running`=0, every slot is forced to IDLE and the spawn counter is held at 0.
- IDLE slot: `x`=203, `y`=90, `anim`=000, animation counter 0.
- Spawn:
  - The spawn counter increments on each tick while running.
  - At the tick where it reaches `SPAWN_PERIOD`-1 and a slot is idle, the lowest-index idle slot enters ROLL at (203,90) with dir=+1. `spawn` pulses and the counter returns to 0.
  - If no slot is idle, the counter holds at its terminal value. The spawn then happens on the first tick after a slot frees.
- Geometry (bottom of barrel: b = y+24, width 32):
  - Floors (lx,ly,rx): (250,53,388), (0,115,591), (49,197,640), (0,286,591), (49,376,640), (0,461,640).
  - Ladders (floor index, x window): (1,539–549), (2,46–56), (3,544–554), (4,51–61).
- Support: b = ly of some floor and x < rx and x+32 > lx.
- ROLL, per tick, in priority order:
  1. Bottom floor (ly=461) and x ≤ 5: retire to IDLE.
  2. No support: go to FALL.
  3. x inside a ladder window on the current floor and a descend decision: go to FALL.
     - Decision by mode: mode 2 always; mode 1 when LFSR bits [2i+1:2i]=2'b10 for slot i; mode 0 never.
  4. Otherwise x += dir·`SPEED_X`.
     - If x+32+`SPEED_X` > 640: clamp x=608 and set dir=−1.
     - If x−`SPEED_X` < 5 (not on the bottom floor): clamp x=5 and set dir=+1.
- FALL, per tick:
  - x is held.
  - If some floor satisfies b < ly ≤ b+`SPEED_Y` and x overlaps it: y = ly−24, state becomes ROLL, and dir inverts.
  - Otherwise y += `SPEED_Y`.
  - Because landing needs strict crossing from above, a ladder descent ignores the floor it started on.
- Animation: a 5-bit per-slot counter increments each tick in ROLL or FALL.
  - ROLL: `anim` = {0, cnt[4:3]}.
  - FALL: `anim` = {10, cnt[4]}.
  - The counter is not reset on a ROLL/FALL transition.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances every clk, independent of `tick`.

## Timing
- All outputs are registered.
- A change caused by tick at edge k is visible after edge k.
- `spawn` is high for exactly one clk, coincident with the slot entering ROLL.
- `rst` mid-flight: on the next edge all slots return to IDLE values, `running`=0, the counter is 0, and the LFSR is reloaded with `LFSR_SEED`.
- `over` with `tick` in the same cycle: `over` wins; no motion is applied.
- `start` while already running: no effect.
- Multiple idle slots: only one spawns per period.

## Structure
- Package `dk_geom_pkg` holds:
  - floor and ladder constant arrays;
  - barrel width/height (32/24);
  - hatch position (203,90);
  - board limits (5, 640);
  - state and anim encodings.
- Sub-module `barrel_slot` implements one slot's FSM, motion and animation. It is instantiated N times via a generate loop.
- The LFSR, `running` flag, spawn counter and lowest-idle priority encoder live at the top level.

## Test plan
- Reset:
  - Stimulus: assert `rst` for 2 cycles.
  - Required: all `x`=203, `y`=90, `state`=00, `anim`=000, `active`=0, `spawn`=0.
- Spawn period:
  - Stimulus: `SPAWN_PERIOD`=4, `tick` every cycle, `start`.
  - Required: spawns into slot 0, 1, 2, 3 at ticks 4, 8, 12, 16.
  - Required: a fifth spawn waits until a slot retires, and the counter holds meanwhile.
- Edge fall and land:
  - Stimulus: `LADDER_MODE`=0.
  - Required: slot 0 rolls right from x=203 and leaves the support of floor 1 (rx=591) at x=591, then enters FALL.
  - Required: it lands with y=173 (197−24) and dir=−1.
- Forced ladder descent:
  - Stimulus: `LADDER_MODE`=2.
  - Required: the first tick at x=539 on floor 1 gives FALL with x=539.
  - Required: it lands on floor 2 at y=173 with dir inverted.
- Retire:
  - Stimulus: a barrel on the bottom floor rolling left.
  - Required: it reaches x=5 and goes IDLE, with `active` dropping the next cycle.
- Abort:
  - Stimulus: assert `over` with three slots active.
  - Required: all slots IDLE after one edge.
  - Required: a following `start` restarts the period count from 0.
